// File: rtl/uart_modport_if.sv
// Serial-side signal bundle for uart_modport: the RX line in, TX line and
// error pulses out. The slave modport is the UART's view, master the driver's.
interface uart_modport_if;
   logic urxd;
   logic utxd;
   logic frame_err;
   logic overflow;

   modport master (output urxd, input utxd, input frame_err, input overflow);
   modport slave  (input urxd, output utxd, output frame_err, output overflow);
endinterface

// File: rtl/uart_modport.sv
// 8N1 UART loopback: received bytes go through a small FIFO and are
// retransmitted on utxd. Reset (rstn) is synchronous and active-high.
module uart_modport #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic           clk,
   input  logic           rstn,
   uart_modport_if.slave  bus
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic rxd_p0, rxd_p1;

   state_t        rx_state, rx_next;
   logic [CW-1:0] rx_cnt, rx_cnt_next;
   logic [2:0]    rx_bit, rx_bit_next;
   logic [7:0]    rx_sh, rx_sh_next;
   logic          rx_push, rx_ferr;

   state_t        tx_state, tx_next;
   logic [CW-1:0] tx_cnt, tx_cnt_next;
   logic [2:0]    tx_bit, tx_bit_next;
   logic [7:0]    tx_sh, tx_sh_next;
   logic          tx_pop, tx_out;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CNTW-1:0] count;
   logic            fifo_nempty, fifo_full, fifo_wr, fifo_drop;
   logic [7:0]      fifo_head;

   logic utxd_r, frame_err_r, overflow_r;

   assign fifo_nempty = (count != '0);
   assign fifo_full   = (count == FULL_CNT);
   assign fifo_head   = mem[rptr];
   // A push into a full FIFO still lands when TX pops the head in the same cycle.
   assign fifo_wr     = rx_push && (!fifo_full || tx_pop);
   assign fifo_drop   = rx_push && fifo_full && !tx_pop;

   assign bus.utxd      = utxd_r;
   assign bus.frame_err = frame_err_r;
   assign bus.overflow  = overflow_r;

   // RX: mid-bit sampling of the synchronized line
   always_comb begin
      rx_next     = rx_state;
      rx_cnt_next = rx_cnt + CW'(1);
      rx_bit_next = rx_bit;
      rx_sh_next  = rx_sh;
      rx_push     = 1'b0;
      rx_ferr     = 1'b0;
      case (rx_state)
         IDLE: begin
            rx_cnt_next = '0;
            if (!rxd_p1) rx_next = START;
         end
         START: if (rx_cnt == HALF_END) begin
            rx_cnt_next = '0;
            rx_bit_next = '0;
            rx_next     = rxd_p1 ? IDLE : DATA;
         end
         DATA: if (rx_cnt == BIT_END) begin
            rx_cnt_next = '0;
            rx_sh_next  = {rxd_p1, rx_sh[7:1]};
            rx_bit_next = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_next = STOP;
         end
         STOP: if (rx_cnt == BIT_END) begin
            rx_cnt_next = '0;
            rx_next     = IDLE;
            if (rxd_p1) rx_push = 1'b1;
            else        rx_ferr = 1'b1;
         end
         default: rx_next = IDLE;
      endcase
   end

   // TX: tx_out is the line value for the next cycle, registered into utxd_r
   always_comb begin
      tx_next     = tx_state;
      tx_cnt_next = tx_cnt + CW'(1);
      tx_bit_next = tx_bit;
      tx_sh_next  = tx_sh;
      tx_pop      = 1'b0;
      tx_out      = 1'b1;
      case (tx_state)
         IDLE: begin
            tx_cnt_next = '0;
            if (fifo_nempty) begin
               tx_pop     = 1'b1;
               tx_sh_next = fifo_head;
               tx_next    = START;
               tx_out     = 1'b0;
            end
         end
         START: begin
            tx_out = 1'b0;
            if (tx_cnt == BIT_END) begin
               tx_cnt_next = '0;
               tx_bit_next = '0;
               tx_next     = DATA;
               tx_out      = tx_sh[0];
            end
         end
         DATA: begin
            tx_out = tx_sh[0];
            if (tx_cnt == BIT_END) begin
               tx_cnt_next = '0;
               tx_sh_next  = {1'b1, tx_sh[7:1]};
               tx_bit_next = tx_bit + 3'd1;
               if (tx_bit == 3'd7) begin
                  tx_next = STOP;
                  tx_out  = 1'b1;
               end else begin
                  tx_out  = tx_sh[1];
               end
            end
         end
         STOP: if (tx_cnt == BIT_END) begin
            tx_cnt_next = '0;
            // Chain straight into the next start bit when more data is queued.
            if (fifo_nempty) begin
               tx_pop     = 1'b1;
               tx_sh_next = fifo_head;
               tx_next    = START;
               tx_out     = 1'b0;
            end else begin
               tx_next    = IDLE;
            end
         end
         default: tx_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         rxd_p0      <= 1'b1;
         rxd_p1      <= 1'b1;
         rx_state    <= IDLE;
         rx_cnt      <= '0;
         rx_bit      <= '0;
         tx_state    <= IDLE;
         tx_cnt      <= '0;
         tx_bit      <= '0;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         utxd_r      <= 1'b1;
         frame_err_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         rxd_p0      <= bus.urxd;
         rxd_p1      <= rxd_p0;
         rx_state    <= rx_next;
         rx_cnt      <= rx_cnt_next;
         rx_bit      <= rx_bit_next;
         tx_state    <= tx_next;
         tx_cnt      <= tx_cnt_next;
         tx_bit      <= tx_bit_next;
         if (fifo_wr) wptr <= wptr + AW'(1);
         if (tx_pop)  rptr <= rptr + AW'(1);
         count       <= count + CNTW'(fifo_wr) - CNTW'(tx_pop);
         utxd_r      <= tx_out;
         frame_err_r <= rx_ferr;
         overflow_r  <= fifo_drop;
      end
   end

   always_ff @(posedge clk) begin
      rx_sh <= rx_sh_next;
      tx_sh <= tx_sh_next;
      if (fifo_wr) mem[wptr] <= rx_sh;
   end

endmodule

// File: tb/tb_uart_modport.sv
// Bench for uart_modport: drives 8N1 frames on urxd, decodes utxd with a
// line monitor and checks decoded bytes against a queue of expected bytes.
module tb_uart_modport;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   uart_modport_if bus ();
   uart_modport #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic       got_stop_q[$];
   int         got_t_q[$];

   int   cyc = 0;
   int   ferr_cnt = 0, ferr_wide = 0, ovf_cnt = 0, ovf_wide = 0;
   logic ferr_prev = 1'b0, ovf_prev = 1'b0;

   logic       mon_prev = 1'b1, mon_busy = 1'b0, mon_flush = 1'b0;
   logic       mon_early = 1'b0, mon_mid = 1'b0;
   logic [7:0] mon_byte = '0;
   int         mon_cnt = 0, mon_start = 0, mon_bad = 0, mon_falls = 0;
   int         mon_idx, mon_ph;

   always @(negedge clk) begin
      cyc++;
      if (bus.frame_err === 1'b1) begin ferr_cnt++; if (ferr_prev) ferr_wide++; end
      if (bus.overflow === 1'b1)  begin ovf_cnt++;  if (ovf_prev)  ovf_wide++;  end
      ferr_prev = (bus.frame_err === 1'b1);
      ovf_prev  = (bus.overflow === 1'b1);

      if (mon_prev && bus.utxd === 1'b0) mon_falls++;
      if (mon_flush) mon_busy = 1'b0;
      else if (!mon_busy) begin
         if (mon_prev && bus.utxd === 1'b0) begin
            mon_busy = 1'b1; mon_cnt = 0; mon_start = cyc; mon_early = 1'b0;
         end
      end else mon_cnt++;
      // Each bit is checked early, mid and late so width errors show up.
      if (mon_busy && !mon_flush) begin
         mon_idx = mon_cnt / CPB;
         mon_ph  = mon_cnt % CPB;
         if (mon_ph == 2) mon_early = bus.utxd;
         if (mon_ph == 8) begin
            mon_mid = bus.utxd;
            if (mon_early !== bus.utxd) mon_bad++;
            if (mon_idx == 0 && bus.utxd !== 1'b0) mon_bad++;
            if (mon_idx >= 1 && mon_idx <= 8) mon_byte[mon_idx-1] = bus.utxd;
         end
         if (mon_ph == 14) begin
            if (mon_mid !== bus.utxd) mon_bad++;
            if (mon_idx == 9) begin
               got_q.push_back(mon_byte);
               got_stop_q.push_back(mon_mid);
               got_t_q.push_back(mon_start);
               mon_busy = 1'b0;
            end
         end
      end
      mon_prev = (bus.utxd !== 1'b0);
   end

   task automatic bits(input logic v, input int n);
      bus.urxd = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      bits(1'b0, CPB);
      for (int i = 0; i < 8; i++) bits(b[i], CPB);
      bits(stop, CPB);
      bus.urxd = 1'b1;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int t = 0;
      while (got_q.size() < n && t < budget) begin @(negedge clk); t++; end
   endtask

   task automatic clear_queues();
      exp_q.delete(); got_q.delete(); got_stop_q.delete(); got_t_q.delete();
   endtask

   task automatic test_reset();
      rstn = 1'b1; bus.urxd = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.utxd !== 1'b1) begin failures++; $display("FAIL reset_utxd got=%b want=1", bus.utxd); end
      checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b want=0", bus.frame_err); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
      rstn = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (bus.utxd !== 1'b1) begin failures++; $display("FAIL idle_utxd got=%b want=1", bus.utxd); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL idle_frames got=%0d want=0", got_q.size()); end
   endtask

   task automatic test_basic();
      int f0 = ferr_cnt, o0 = ovf_cnt, b0 = mon_bad;
      logic [7:0] g, e;
      logic s;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      wait_frames(1, 3 * FRAME);
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL basic_count got=%0d want=1", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); s = got_stop_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL basic_byte got=%h want=%h", g, e); end
         checks++; if (s !== 1'b1) begin failures++; $display("FAIL basic_stop got=%b want=1", s); end
      end
      checks++; if (mon_bad != b0) begin failures++; $display("FAIL basic_bitwidth bad=%0d want=%0d", mon_bad, b0); end
      checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL basic_ferr got=%0d want=%0d", ferr_cnt, f0); end
      checks++; if (ovf_cnt != o0) begin failures++; $display("FAIL basic_ovf got=%0d want=%0d", ovf_cnt, o0); end
      repeat (2 * CPB) @(negedge clk);
      clear_queues();
   endtask

   task automatic test_frame_err();
      int f0 = ferr_cnt, w0 = ferr_wide, o0 = ovf_cnt, fl0 = mon_falls;
      send_frame(8'hA3, 1'b0);
      repeat (2 * FRAME) @(negedge clk);
      checks++; if (ferr_cnt != f0 + 1) begin failures++; $display("FAIL ferr_pulses got=%0d want=%0d", ferr_cnt - f0, 1); end
      checks++; if (ferr_wide != w0) begin failures++; $display("FAIL ferr_width got=%0d want=%0d", ferr_wide, w0); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ferr_tx got=%0d want=0", got_q.size()); end
      checks++; if (mon_falls != fl0) begin failures++; $display("FAIL ferr_utxd falls=%0d want=%0d", mon_falls, fl0); end
      checks++; if (ovf_cnt != o0) begin failures++; $display("FAIL ferr_ovf got=%0d want=%0d", ovf_cnt, o0); end
      clear_queues();
   endtask

   task automatic test_glitch();
      int f0 = ferr_cnt, fl0 = mon_falls;
      bits(1'b0, 4);
      bits(1'b1, 2 * FRAME);
      checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL glitch_ferr got=%0d want=%0d", ferr_cnt, f0); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_tx got=%0d want=0", got_q.size()); end
      checks++; if (mon_falls != fl0) begin failures++; $display("FAIL glitch_utxd falls=%0d want=%0d", mon_falls, fl0); end
      clear_queues();
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [3] = '{8'h00, 8'hFF, 8'h81};
      int f0 = ferr_cnt, b0 = mon_bad;
      int t_prev = -1, t;
      logic [7:0] g, e;
      logic s;
      for (int i = 0; i < 3; i++) exp_q.push_back(pat[i]);
      for (int i = 0; i < 3; i++) send_frame(pat[i], 1'b1);
      wait_frames(3, 4 * FRAME);
      checks++; if (got_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front(); s = got_stop_q.pop_front(); t = got_t_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL b2b_byte got=%h want=%h", g, e); end
         checks++; if (s !== 1'b1) begin failures++; $display("FAIL b2b_stop got=%b want=1", s); end
         if (t_prev >= 0) begin
            checks++; if (t - t_prev != FRAME) begin failures++; $display("FAIL b2b_gap got=%0d want=%0d", t - t_prev, FRAME); end
         end
         t_prev = t;
      end
      checks++; if (mon_bad != b0) begin failures++; $display("FAIL b2b_bitwidth bad=%0d want=%0d", mon_bad, b0); end
      checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL b2b_ferr got=%0d want=%0d", ferr_cnt, f0); end
      repeat (2 * CPB) @(negedge clk);
      clear_queues();
   endtask

   task automatic test_reset_mid_tx();
      int t = 0, fl0;
      int f0 = ferr_cnt;
      send_frame(8'h0F, 1'b1);
      while (!(mon_busy && mon_cnt >= 4 * CPB + 8) && t < 3 * FRAME) begin @(negedge clk); t++; end
      checks++; if (!(mon_busy && mon_cnt >= 4 * CPB + 8)) begin failures++; $display("FAIL rst_tx_start busy=%b want=1", mon_busy); end
      mon_flush = 1'b1;
      rstn = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      fl0 = mon_falls;
      checks++; if (bus.utxd !== 1'b1) begin failures++; $display("FAIL rst_utxd got=%b want=1", bus.utxd); end
      repeat (2 * FRAME) @(negedge clk);
      checks++; if (mon_falls != fl0) begin failures++; $display("FAIL rst_no_tx falls=%0d want=%0d", mon_falls, fl0); end
      checks++; if (bus.utxd !== 1'b1) begin failures++; $display("FAIL rst_idle_utxd got=%b want=1", bus.utxd); end
      checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL rst_ferr got=%0d want=%0d", ferr_cnt, f0); end
      mon_flush = 1'b0;
      clear_queues();
   endtask

   task automatic test_overflow();
      logic [7:0] pat [5] = '{8'hC3, 8'h5A, 8'hE7, 8'h18, 8'h99};
      int o0 = ovf_cnt, w0 = ovf_wide, fl0 = mon_falls, f0 = ferr_cnt;
      logic [7:0] g, e;
      force dut.fifo_nempty = 1'b0;
      for (int i = 0; i < 4; i++) begin exp_q.push_back(pat[i]); send_frame(pat[i], 1'b1); end
      repeat (CPB) @(negedge clk);
      checks++; if (ovf_cnt != o0) begin failures++; $display("FAIL ovf_early got=%0d want=%0d", ovf_cnt, o0); end
      send_frame(pat[4], 1'b1);
      repeat (CPB) @(negedge clk);
      checks++; if (ovf_cnt != o0 + 1) begin failures++; $display("FAIL ovf_pulse got=%0d want=%0d", ovf_cnt - o0, 1); end
      checks++; if (ovf_wide != w0) begin failures++; $display("FAIL ovf_width got=%0d want=%0d", ovf_wide, w0); end
      checks++; if (mon_falls != fl0) begin failures++; $display("FAIL ovf_hold falls=%0d want=%0d", mon_falls, fl0); end
      release dut.fifo_nempty;
      wait_frames(4, 6 * FRAME);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovf_count got=%0d want=4", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g !== e) begin failures++; $display("FAIL ovf_byte got=%h want=%h", g, e); end
      end
      repeat (2 * FRAME) @(negedge clk);
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ovf_extra got=%0d want=0", got_q.size()); end
      checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL ovf_ferr got=%0d want=%0d", ferr_cnt, f0); end
      clear_queues();
   endtask

   initial begin
      bus.urxd = 1'b1;
      test_reset();
      test_basic();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid_tx();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time=%0t limit=1000000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
